// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: latches one load/store request and drives exactly one memory cycle.
// Load data is returned in a register. Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word requests.
module dmem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_mask,
    output logic        mem_signed_ext,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e              state_q;
    logic                we_q;
    logic                ready_q;
    logic                done_q;
    logic                addr_err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic [MASK_W-1:0]   mem_mask_q;
    logic                mem_sext_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [MASK_W-1:0]   mask_d;
    logic                sext_d;
    logic                misalign_c;

    // Size code 11 is treated as a word access.
    assign mask_d = (req_op[1:0] == 2'b11) ? 2'b10 : req_op[1:0];
    assign sext_d = ~req_we & ~req_op[2];

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        misalign_c = 1'b0;
        case (req_op[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = req_addr[0];
            default: misalign_c = |req_addr[1:0];
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Single-process FSM; every output is a flop so the memory interface never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_mask_q  <= '0;
            mem_sext_q  <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q        <= req_we;
                        mem_addr_q  <= req_addr;
                        mem_mask_q  <= mask_d;
                        mem_sext_q  <= sext_d;
                        mem_wdata_q <= req_wdata;
                        ready_q     <= 1'b0;
                        if (misalign_c) begin
                            state_q    <= ERR;
                            done_q     <= 1'b1;
                            addr_err_q <= 1'b1;
                            rdata_q    <= '0;
                        end else begin
                            state_q  <= XFER;
                            mem_we_q <= req_we;
                        end
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    done_q  <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                ERR: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready          = ready_q;
    assign done           = done_q;
    assign addr_err       = addr_err_q;
    assign rdata          = rdata_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_mask       = mem_mask_q;
    assign mem_signed_ext = mem_sext_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
